// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/response bundle between the EX stage and div_unit
// Purpose: groups the start/ready/valid handshake, operands and result of the
//   iterative divider so the pipeline and the divider share one port.
// Signals:
//   i_start     request strobe, accepted only while o_ready=1
//   i_div_op    00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_op_a      dividend
//   i_op_b      divisor
//   i_flush     synchronous abort
//   o_ready     divider idle
//   o_valid     one-cycle result strobe
//   o_div_data  quotient or remainder, held until the next accept
// Modports: master (pipeline side), slave (divider side).
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic [1:0]       i_div_op;
   logic [WIDTH-1:0] i_op_a;
   logic [WIDTH-1:0] i_op_b;
   logic             i_flush;
   logic             o_ready;
   logic             o_valid;
   logic [WIDTH-1:0] o_div_data;

   modport master (
      output i_start, i_div_op, i_op_a, i_op_b, i_flush,
      input  o_ready, o_valid, o_div_data
   );

   modport slave (
      input  i_start, i_div_op, i_op_a, i_op_b, i_flush,
      output o_ready, o_valid, o_div_data
   );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Purpose: one quotient bit per clock on operand magnitudes, sign fix-up and the
//   divide-by-zero / signed-overflow results applied when the result is registered.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      div_unit_if.slave (start/op/operands/flush in, ready/valid/data out)
// Configuration:
//   DIV_EARLY_OUT_EN  when defined, divide-by-zero, signed overflow and |a|<|b|
//                     skip the iteration and finish on the accept edge.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   div_unit_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    count;
   logic             sel_rem;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic             neg_q;
   logic             neg_r;
   logic             div0;
   logic             ovf;
   logic [WIDTH-1:0] data;

   // ---------------- accept-side decode ----------------
   logic             accept;
   logic             is_signed;
   logic             in_neg_a;
   logic             in_neg_b;
   logic [WIDTH-1:0] in_mag_a;
   logic [WIDTH-1:0] in_mag_b;
   logic             in_div0;
   logic             in_ovf;
   logic             early;
   logic [WIDTH-1:0] early_result;

   assign accept    = (state == IDLE) && bus.i_start && !bus.i_flush;
   assign is_signed = ~bus.i_div_op[0];
   assign in_neg_a  = is_signed & bus.i_op_a[WIDTH-1];
   assign in_neg_b  = is_signed & bus.i_op_b[WIDTH-1];
   assign in_mag_a  = in_neg_a ? -bus.i_op_a : bus.i_op_a;
   assign in_mag_b  = in_neg_b ? -bus.i_op_b : bus.i_op_b;
   assign in_div0   = (bus.i_op_b == '0);
   assign in_ovf    = is_signed && (bus.i_op_a == MIN_NEG) && (bus.i_op_b == '1);

`ifdef DIV_EARLY_OUT_EN
   // Trivial cases are fully known at accept: the quotient of |a|<|b| is 0 and
   // its remainder is the dividend itself, sign included.
   assign early = in_div0 || in_ovf || (in_mag_a < in_mag_b);

   always_comb begin
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      q = '0;
      r = bus.i_op_a;
      if (in_div0) begin
         q = '1;
      end else if (in_ovf) begin
         q = MIN_NEG;
         r = '0;
      end
      early_result = bus.i_div_op[1] ? r : q;
   end
`else
   assign early        = 1'b0;
   assign early_result = '0;
`endif

   // ---------------- one restoring step ----------------
   // The shifted partial remainder can reach 2|b|-1, so it carries one extra bit;
   // when the trial subtraction succeeds the difference is below |b| and fits WIDTH.
   logic [WIDTH:0]   partial;
   logic             borrow;
   logic [WIDTH-1:0] sub;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;

   assign partial  = {rem, quo[WIDTH-1]};
   assign borrow   = partial < {1'b0, mag_b};
   assign sub      = partial[WIDTH-1:0] - mag_b;
   assign rem_next = borrow ? partial[WIDTH-1:0] : sub;
   assign quo_next = {quo[WIDTH-2:0], ~borrow};

   // Final result from the last step, with sign fix-up and forced special cases.
   logic [WIDTH-1:0] calc_result;

   always_comb begin
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      q = neg_q ? -quo_next : quo_next;
      r = neg_r ? -rem_next : rem_next;
      if (div0) begin
         q = '1;
         r = dividend;
      end else if (ovf) begin
         q = MIN_NEG;
         r = '0;
      end
      calc_result = sel_rem ? r : q;
   end

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (bus.i_flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: if (bus.i_start) state_next = early ? DONE : CALC;
            CALC: if (count == CW'(1)) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.o_ready = (state == IDLE);
      bus.o_valid = (state == DONE);
   end

   assign bus.o_div_data = data;

   // ---------------- datapath ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count    <= '0;
         sel_rem  <= 1'b0;
         dividend <= '0;
         mag_b    <= '0;
         quo      <= '0;
         rem      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div0     <= 1'b0;
         ovf      <= 1'b0;
         data     <= '0;
      end else if (accept) begin
         sel_rem  <= bus.i_div_op[1];
         dividend <= bus.i_op_a;
         mag_b    <= in_mag_b;
         quo      <= in_mag_a;
         rem      <= '0;
         neg_q    <= in_neg_a ^ in_neg_b;
         neg_r    <= in_neg_a;
         div0     <= in_div0;
         ovf      <= in_ovf;
         if (early) begin
            count <= '0;
            data  <= early_result;
         end else begin
            count <= CW'(WIDTH);
         end
      end else if (bus.i_flush) begin
         // Aborted op: iteration stops, the previously delivered result stays visible.
         count <= '0;
      end else if (state == CALC) begin
         quo   <= quo_next;
         rem   <= rem_next;
         count <= count - CW'(1);
         if (count == CW'(1)) begin
            data <= calc_result;
         end
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;
   logic i_clk;
   logic i_rst_n;
   int   tests;
   int   fails;
   logic [31:0] last_exp;

`ifdef DIV_EARLY_OUT_EN
   localparam int LE = 0;
`else
   localparam int LE = 32;
`endif
   localparam int LF = 32;

   div_unit_if #(.WIDTH(32)) bus ();

   div_unit #(.WIDTH(32)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus.slave)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Edges after the accept edge until o_valid is seen (0 = valid right after accept).
   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.o_valid && n < 100) begin
         @(posedge i_clk);
         #1;
         n++;
      end
   endtask

   task automatic count_valids(input int cycles, output int v);
      v = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge i_clk);
         #1;
         if (bus.o_valid) v++;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int n;
      bus.i_start  = 1'b1;
      bus.i_div_op = op;
      bus.i_op_a   = a;
      bus.i_op_b   = b;
      @(posedge i_clk);
      #1;
      bus.i_start = 1'b0;
      wait_valid(n);
      check({tag, "_data"}, bus.o_div_data, exp);
      check({tag, "_lat"}, n, exp_lat);
      @(posedge i_clk);
      #1;
      check({tag, "_pulse"}, {31'd0, bus.o_valid}, 32'd0);
      check({tag, "_held"}, bus.o_div_data, exp);
      last_exp = exp;
   endtask

   initial begin
      int n;
      int v;
      tests = 0;
      fails = 0;
      last_exp = '0;
      bus.i_start  = 1'b0;
      bus.i_div_op = 2'b00;
      bus.i_op_a   = '0;
      bus.i_op_b   = '0;
      bus.i_flush  = 1'b0;
      i_rst_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
      check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
      check("rst_data", bus.o_div_data, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'h0000_000E, LF);
      run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'h0000_0002, LF);
      run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LF);
      run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LF);
      run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, LF);
      run_op("div_m8_m3", 2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'h0000_0002, LF);
      run_op("rem_m8_m3", 2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, LF);
      run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LF);
      run_op("remu_max_big", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LF);
      run_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, LE);
      run_op("rem_5_0", 2'b10, 32'd5, 32'd0, 32'h0000_0005, LE);
      run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, LE);
      run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LE);
      run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LE);
      run_op("divu_ovfpat", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LE);
      run_op("rem_small", 2'b10, 32'hFFFF_FFF9, 32'd8, 32'hFFFF_FFF9, LE);

      // Flush during CALC after 9 iterations.
      bus.i_start  = 1'b1;
      bus.i_div_op = 2'b01;
      bus.i_op_a   = 32'd100;
      bus.i_op_b   = 32'd7;
      @(posedge i_clk);
      #1;
      bus.i_start = 1'b0;
      repeat (9) @(posedge i_clk);
      #1;
      check("flush_busy", {31'd0, bus.o_ready}, 32'd0);
      bus.i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      bus.i_flush = 1'b0;
      check("flush_ready", {31'd0, bus.o_ready}, 32'd1);
      check("flush_data", bus.o_div_data, last_exp);
      count_valids(40, v);
      check("flush_novalid", v, 32'd0);
      run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'h0000_0003, LF);

      // Flush and start together in IDLE: nothing accepted.
      bus.i_start  = 1'b1;
      bus.i_flush  = 1'b1;
      bus.i_div_op = 2'b01;
      bus.i_op_a   = 32'd50;
      bus.i_op_b   = 32'd5;
      @(posedge i_clk);
      #1;
      bus.i_start = 1'b0;
      bus.i_flush = 1'b0;
      check("flush_start_ready", {31'd0, bus.o_ready}, 32'd1);
      count_valids(40, v);
      check("flush_start_novalid", v, 32'd0);
      check("flush_start_data", bus.o_div_data, 32'h0000_0003);

      // Asynchronous reset in the middle of CALC.
      bus.i_start  = 1'b1;
      bus.i_div_op = 2'b01;
      bus.i_op_a   = 32'd100;
      bus.i_op_b   = 32'd7;
      @(posedge i_clk);
      #1;
      bus.i_start = 1'b0;
      repeat (5) @(posedge i_clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("arst_ready", {31'd0, bus.o_ready}, 32'd1);
      check("arst_valid", {31'd0, bus.o_valid}, 32'd0);
      check("arst_data", bus.o_div_data, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      // i_start held with changing operands during CALC.
      bus.i_start  = 1'b1;
      bus.i_div_op = 2'b01;
      bus.i_op_a   = 32'd100;
      bus.i_op_b   = 32'd7;
      @(posedge i_clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         bus.i_op_a   = 32'(i * 1000 + 5);
         bus.i_op_b   = 32'(i + 3);
         bus.i_div_op = 2'(i);
         @(posedge i_clk);
         #1;
      end
      wait_valid(n);
      check("hold_data", bus.o_div_data, 32'h0000_000E);
      check("hold_lat", 10 + n, 32'd32);
      bus.i_div_op = 2'b01;
      bus.i_op_a   = 32'd50;
      bus.i_op_b   = 32'd5;
      @(posedge i_clk);
      #1;
      check("hold_idle_ready", {31'd0, bus.o_ready}, 32'd1);
      check("hold_idle_valid", {31'd0, bus.o_valid}, 32'd0);
      @(posedge i_clk);
      #1;
      bus.i_start = 1'b0;
      check("second_busy", {31'd0, bus.o_ready}, 32'd0);
      wait_valid(n);
      check("second_data", bus.o_div_data, 32'h0000_000A);
      check("second_lat", n, 32'd32);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
